// File: rtl/ofdm_tx_pkg.sv
// Shared constants for the OFDM TX frame builder: segment lengths, state encoding
// and the STS/LTS preamble tables (signed, same full scale as the data samples).
package ofdm_tx_pkg;

    localparam int DW       = 8;
    localparam int STS_LEN  = 16;
    localparam int STS_REPS = 10;
    localparam int LTS_GI   = 32;
    localparam int LTS_LEN  = 64;
    localparam int LTS_REPS = 2;
    localparam int IFS_LEN  = 16;

    localparam int STS_TOTAL = STS_LEN * STS_REPS;
    localparam int LTS_TOTAL = LTS_LEN * LTS_REPS;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_SEG = max2(max2(STS_TOTAL, LTS_GI), max2(LTS_TOTAL, IFS_LEN));
    localparam int CNT_W   = $clog2(MAX_SEG);
    localparam int STS_AW  = $clog2(STS_LEN);
    localparam int ROM_AW  = $clog2(LTS_LEN);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STS    = 3'd1,
        ST_LTS_GI = 3'd2,
        ST_LTS    = 3'd3,
        ST_DATA   = 3'd4,
        ST_IFS    = 3'd5
    } state_t;

    localparam int STS_I [STS_LEN] = '{
         32, -92,  -9, 100,  64, 100,  -9, -92,  32,   1, -55,  -9,   0,  -9, -55,   1
    };
    localparam int STS_Q [STS_LEN] = '{
         32,   1, -55,  -9,   0,  -9, -55,   1,  32, -92,  -9, 100,  64, 100,  -9, -92
    };

    localparam int LTS_I [LTS_LEN] = '{
         110,  -4,  28,  68,  15,  42, -80, -27,  69,  37,   1, -96,  17,  41, -15,  83,
          44, -90, -23, -56,  10, -49, -52,  48, -20, -44,  67, -29, -19,  82,  25, -40,
        -100,  40,   7, -30, -83, -66,  21, -12, -33,  24,-105,   1,  58, -64,  -4,  -3,
          60,   3, -26, -78,  49,  11, -52, -57,   1, -70,  -7,  43,  18,  14, -17,  35
    };
    localparam int LTS_Q [LTS_LEN] = '{
           0, -84, -78,  58,  20, -62, -39, -74, -18,   3, -81, -33, -41, -11, 113,  -3,
          43, -88, -70,   9, -41,  24, -57,  66,  24,  10,  31,-103, -51,  26,  -8,  41,
           0, -41,   8,  51, -25, -43, -36, -19, -90,  15, -12,  -8, -24,  88,  -8, -17,
          58, -31, -47, -12, -20,  65, -60,  46, -76, -41, -15,  -2,  59,  36,  38, -56
    };

endpackage

// File: rtl/tx_preamble_rom.sv
// Synchronous-read preamble ROM; sel_sts picks the STS table, otherwise the LTS table.
module tx_preamble_rom
    import ofdm_tx_pkg::*;
(
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     sel_sts,
    input  logic [ROM_AW-1:0]        addr,
    output logic signed [DW-1:0]     samp_re,
    output logic signed [DW-1:0]     samp_im
);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            samp_re <= '0;
            samp_im <= '0;
        end else if (sel_sts) begin
            samp_re <= DW'(STS_I[addr[STS_AW-1:0]]);
            samp_im <= DW'(STS_Q[addr[STS_AW-1:0]]);
        end else begin
            samp_re <= DW'(LTS_I[addr]);
            samp_im <= DW'(LTS_Q[addr]);
        end
    end

endmodule

// File: rtl/ofdm_tx_frame_builder.sv
// OFDM TX burst builder: STS, LTS guard + LTS symbols, caller data, inter-frame gap.
// state   | meaning
// IDLE    | waiting for din_vld to start a frame
// STS     | short training periods from ROM
// LTS_GI  | tail of the LTS symbol used as guard
// LTS     | full LTS symbols from ROM
// DATA    | din passed through, zeros with underrun when din_vld is low
// IFS     | zero samples with dout_vld high
module ofdm_tx_frame_builder
    import ofdm_tx_pkg::*;
(
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          din_vld,
    input  logic [DW-1:0] din_R,
    input  logic [DW-1:0] din_I,
    input  logic          din_last,
    output logic          din_rdy,
    output logic          dout_vld,
    output logic [DW-1:0] dout_R,
    output logic [DW-1:0] dout_I,
    output logic          dout_sof,
    output logic          dout_eof,
    output logic          underrun
);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 rom_sel_sts;
    logic [ROM_AW-1:0]    rom_addr;
    logic signed [DW-1:0] rom_re;
    logic signed [DW-1:0] rom_im;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (din_vld) state_nxt = ST_STS;
            ST_STS:    if (cnt == CNT_W'(STS_TOTAL - 1)) state_nxt = ST_LTS_GI;
            ST_LTS_GI: if (cnt == CNT_W'(LTS_GI - 1)) state_nxt = ST_LTS;
            ST_LTS:    if (cnt == CNT_W'(LTS_TOTAL - 1)) state_nxt = ST_DATA;
            ST_DATA:   if (din_vld && din_last) state_nxt = (IFS_LEN == 0) ? ST_IDLE : ST_IFS;
            ST_IFS:    if (cnt == CNT_W'(IFS_LEN - 1)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase

        // DATA has no length bound, so the counter is parked there instead of counting.
        if (state_nxt != state || state == ST_DATA || state == ST_IDLE)
            cnt_nxt = '0;
        else
            cnt_nxt = cnt + 1'b1;
    end

    // The ROM is addressed from next-state/next-count so its registered output
    // lines up with the state register one cycle later.
    always_comb begin
        rom_sel_sts = (state_nxt == ST_STS);
        rom_addr    = '0;
        case (state_nxt)
            ST_STS:    rom_addr = {{(ROM_AW - STS_AW){1'b0}}, cnt_nxt[STS_AW-1:0]};
            ST_LTS_GI: rom_addr = ROM_AW'(LTS_LEN - LTS_GI) + cnt_nxt[ROM_AW-1:0];
            ST_LTS:    rom_addr = cnt_nxt[ROM_AW-1:0];
            default:   rom_addr = '0;
        endcase
    end

    tx_preamble_rom u_rom (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .sel_sts (rom_sel_sts),
        .addr    (rom_addr),
        .samp_re (rom_re),
        .samp_im (rom_im)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            din_rdy  <= 1'b0;
            dout_vld <= 1'b0;
            dout_R   <= '0;
            dout_I   <= '0;
            dout_sof <= 1'b0;
            dout_eof <= 1'b0;
            underrun <= 1'b0;
        end else begin
            din_rdy  <= (state_nxt == ST_DATA);
            dout_vld <= 1'b0;
            dout_R   <= '0;
            dout_I   <= '0;
            dout_sof <= 1'b0;
            dout_eof <= 1'b0;
            underrun <= 1'b0;
            case (state)
                ST_STS, ST_LTS_GI, ST_LTS: begin
                    dout_vld <= 1'b1;
                    dout_R   <= rom_re;
                    dout_I   <= rom_im;
                    dout_sof <= (state == ST_STS) && (cnt == '0);
                end
                ST_DATA: begin
                    dout_vld <= 1'b1;
                    if (din_vld) begin
                        dout_R   <= din_R;
                        dout_I   <= din_I;
                        dout_eof <= din_last;
                    end else begin
                        underrun <= 1'b1;
                    end
                end
                ST_IFS: dout_vld <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
